// File: rtl/n2_idu_iq.sv
// N2 IDU instruction queue: buffers predecoded uops with their PCs between fetch and decode.
// In-order, registered output, redirect flush empties the queue.

package n2_idu_pkg;

    typedef struct packed {
        logic [6:0] opcode;
        logic [4:0] rd;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [2:0] fu_type;
        logic       is_branch;
        logic       is_load;
        logic       is_store;
        logic       instr_trap;
    } uop_ctl_t;

    localparam int UOP_W = $bits(uop_ctl_t);

endpackage

module n2_idu_iq #(
    parameter int DEPTH     = 4,
    parameter int AFULL_LVL = 3
) (
    input  logic                            clk_i,
    input  logic                            rst_n_i,
    input  logic                            flush_i,
    input  logic                            wr_valid_i,
    output logic                            wr_ready_o,
    input  logic [31:0]                     wr_pc_i,
    input  logic [n2_idu_pkg::UOP_W-1:0]    wr_uop_i,
    output logic                            rd_valid_o,
    input  logic                            rd_ready_i,
    output logic [31:0]                     rd_pc_o,
    output logic [n2_idu_pkg::UOP_W-1:0]    rd_uop_o,
    output logic [$clog2(DEPTH+1)-1:0]      count_o,
    output logic                            afull_o
);

    localparam int UOP_W = n2_idu_pkg::UOP_W;
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    logic [31:0]      mem_pc  [DEPTH];
    logic [UOP_W-1:0] mem_uop [DEPTH];

    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0] count;
    logic             push, pop;

    // Ready is a function of local state and flush only, so no rd->wr combinational path.
    assign wr_ready_o = (count != CNT_W'(DEPTH)) & ~flush_i;
    assign rd_valid_o = (count != '0);
    assign push       = wr_valid_i & wr_ready_o;
    assign pop        = rd_valid_o & rd_ready_i;

    assign rd_pc_o  = mem_pc[rd_ptr];
    assign rd_uop_o = mem_uop[rd_ptr];
    assign count_o  = count;
    assign afull_o  = (count >= CNT_W'(AFULL_LVL));

    // Storage is deliberately not reset; outputs are only meaningful when rd_valid_o is set.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_pc[wr_ptr]  <= wr_pc_i;
            mem_uop[wr_ptr] <= wr_uop_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    a_count_le_depth: assert property (@(posedge clk_i) disable iff (!rst_n_i)
        count <= CNT_W'(DEPTH));
    a_no_underflow: assert property (@(posedge clk_i) disable iff (!rst_n_i)
        (count == '0) |-> !pop);
    a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_n_i)
        (count == CNT_W'(DEPTH)) |-> !push);

endmodule

// File: tb/tb_n2_idu_iq.sv
// Directed bench for n2_idu_iq: fill/drain, streaming with pointer wrap, flush, latency, async reset.

module tb_n2_idu_iq;

    localparam int DEPTH = 4;
    localparam int UOP_W = n2_idu_pkg::UOP_W;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             flush;
    logic             wr_valid;
    logic             wr_ready;
    logic [31:0]      wr_pc;
    logic [UOP_W-1:0] wr_uop;
    logic             rd_valid;
    logic             rd_ready;
    logic [31:0]      rd_pc;
    logic [UOP_W-1:0] rd_uop;
    logic [2:0]       count;
    logic             afull;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    n2_idu_iq #(.DEPTH(DEPTH), .AFULL_LVL(3)) dut (
        .clk_i      (clk),
        .rst_n_i    (rst_n),
        .flush_i    (flush),
        .wr_valid_i (wr_valid),
        .wr_ready_o (wr_ready),
        .wr_pc_i    (wr_pc),
        .wr_uop_i   (wr_uop),
        .rd_valid_o (rd_valid),
        .rd_ready_i (rd_ready),
        .rd_pc_o    (rd_pc),
        .rd_uop_o   (rd_uop),
        .count_o    (count),
        .afull_o    (afull)
    );

    function automatic logic [UOP_W-1:0] uop_of(input logic [31:0] pc);
        logic [31:0] h;
        h = pc * 32'h0100_0193 + 32'h2545_F491;
        return h[UOP_W-1:0];
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_push(input logic [31:0] pc);
        wr_valid = 1'b1;
        wr_pc    = pc;
        wr_uop   = uop_of(pc);
    endtask

    initial begin
        n2_idu_pkg::uop_ctl_t trap_uop;

        rst_n = 1'b0; flush = 1'b0; wr_valid = 1'b0; rd_ready = 1'b0;
        wr_pc = '0; wr_uop = '0;
        #3;
        check("rst_rd_valid", rd_valid, 0);
        check("rst_count",    count,    0);
        check("rst_afull",    afull,    0);
        check("rst_wr_ready", wr_ready, 1);
        step(); step();
        rst_n = 1'b1;
        step();

        // 1: fill to full with the consumer stalled
        for (int i = 0; i < 4; i++) begin
            drive_push(32'(i * 4));
            step();
            check($sformatf("fill_count_%0d", i), count, 64'(i + 1));
            check($sformatf("fill_afull_%0d", i), afull, (i + 1 >= 3) ? 1 : 0);
            check($sformatf("fill_wrrdy_%0d", i), wr_ready, (i + 1 != 4) ? 1 : 0);
        end
        drive_push(32'h10);
        step();
        check("full_hold_count", count, 4);
        check("full_hold_wrrdy", wr_ready, 0);
        check("full_head_pc",    rd_pc, 0);
        wr_valid = 1'b0;

        // 2: drain in order
        rd_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("drain_valid_%0d", i), rd_valid, 1);
            check($sformatf("drain_pc_%0d", i), rd_pc, 64'(i * 4));
            check($sformatf("drain_uop_%0d", i), rd_uop, uop_of(32'(i * 4)));
            step();
        end
        check("drain_empty_valid", rd_valid, 0);
        check("drain_empty_count", count, 0);
        rd_ready = 1'b0;

        // 3: stream at count 2 so both pointers wrap
        drive_push(32'h40); step();
        drive_push(32'h44); step();
        check("stream_start_count", count, 2);
        rd_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            drive_push(32'h48 + 32'(4 * k));
            #1;
            check($sformatf("stream_pc_%0d", k), rd_pc, 64'(32'h40 + 4 * k));
            step();
            check($sformatf("stream_count_%0d", k), count, 2);
        end
        wr_valid = 1'b0; rd_ready = 1'b0;
        check("stream_tail_pc", rd_pc, 32'h68);
        drive_push(32'h70); step();
        wr_valid = 1'b0;
        check("pre_flush_count", count, 3);

        // 4: flush with push and pop both requested
        flush = 1'b1; rd_ready = 1'b1; drive_push(32'h200);
        #1;
        check("flush_wr_ready", wr_ready, 0);
        check("flush_rd_valid", rd_valid, 1);
        step();
        flush = 1'b0; wr_valid = 1'b0; rd_ready = 1'b0;
        check("post_flush_count", count, 0);
        check("post_flush_valid", rd_valid, 0);
        drive_push(32'h100);
        #1;
        check("post_flush_wrrdy", wr_ready, 1);
        step();
        wr_valid = 1'b0;
        check("post_flush_head_valid", rd_valid, 1);
        check("post_flush_head_pc",    rd_pc, 32'h100);
        check("post_flush_head_count", count, 1);
        rd_ready = 1'b1; step(); rd_ready = 1'b0;
        check("post_flush_drained", count, 0);

        // 5: one-cycle latency, trap uop stored unmodified
        trap_uop = '0;
        trap_uop.opcode = 7'h73;
        trap_uop.instr_trap = 1'b1;
        wr_valid = 1'b1; wr_pc = 32'h20; wr_uop = trap_uop;
        #1;
        check("lat_before_valid", rd_valid, 0);
        step();
        wr_valid = 1'b0;
        check("lat_after_valid", rd_valid, 1);
        check("lat_after_pc",    rd_pc, 32'h20);
        check("lat_trap_uop",    rd_uop, trap_uop);

        // 6: async reset mid-cycle at count 3
        drive_push(32'h24); step();
        drive_push(32'h28); step();
        wr_valid = 1'b0;
        check("pre_areset_count", count, 3);
        #2;
        rst_n = 1'b0;
        #1;
        check("areset_valid", rd_valid, 0);
        check("areset_count", count, 0);
        check("areset_afull", afull, 0);
        check("areset_wrrdy", wr_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        drive_push(32'h300); step();
        wr_valid = 1'b0;
        check("fresh_count", count, 1);
        check("fresh_head_pc", rd_pc, 32'h300);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
